// File: rtl/rv_fetch_pkg.sv
// Shared types for the instruction-fetch stage.
// FSM states, NOP encoding and the presented-entry bundle.
package rv_fetch_pkg;

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_DROP
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        valid;
   } fetch_entry_t;

   localparam fetch_entry_t EMPTY_ENTRY = '{
      pc:    32'h0,
      instr: NOP_INSTR,
      valid: 1'b0
   };

endpackage

// File: rtl/fetch_skid_buf.sv
// Output register plus one-entry skid for fetched instructions.
// Absorbs a response that lands while the output is held.
module fetch_skid_buf
   import rv_fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  fetch_entry_t push_entry,
   input  logic         consume,
   input  logic         clear,
   output fetch_entry_t out_entry,
   output logic         skid_full
);

   fetch_entry_t out_q;
   fetch_entry_t skid_q;
   logic         take;

   assign take      = consume && out_q.valid;
   assign out_entry = out_q;
   assign skid_full = skid_q.valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q  <= EMPTY_ENTRY;
         skid_q <= EMPTY_ENTRY;
      end else if (clear) begin
         out_q  <= EMPTY_ENTRY;
         skid_q <= EMPTY_ENTRY;
      end else if (take) begin
         if (skid_q.valid) begin
            out_q  <= skid_q;
            skid_q <= EMPTY_ENTRY;
         end else if (push) begin
            out_q <= push_entry;
         end else begin
            out_q <= EMPTY_ENTRY;
         end
      end else if (push) begin
         if (!out_q.valid) begin
            out_q <= push_entry;
         end else begin
            skid_q <= push_entry;
         end
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem handshake,
// and the PC / PC+4 / instruction bundle feeding IF/ID.
module if_fetch_stage
   import rv_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_disable,
   input  logic        flush,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PC_IFID_in,
   output logic [31:0] PC_plus4_IFID_in,
   output logic [31:0] instruction_IFID_in,
   output logic        valid_IFID_in
);

   localparam logic [31:0] START_PC = RESET_PC & ~32'h3;

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  req_pc_q, req_pc_d;
   logic         run_q;
   logic         push;
   logic         gnt_ok;
   logic         skid_full;
   fetch_entry_t push_entry;
   fetch_entry_t out_entry;

   // run_q keeps imem_req low through reset and its release cycle
   assign imem_req  = run_q && (state_q == S_REQ) && !skid_full;
   assign imem_addr = pc_q;
   assign gnt_ok    = imem_req && imem_gnt;

   assign push_entry = '{
      pc:    req_pc_q,
      instr: imem_rdata,
      valid: 1'b1
   };

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      push     = 1'b0;
      unique case (state_q)
         S_REQ: begin
            if (gnt_ok) begin
               req_pc_d = pc_q;
               pc_d     = pc_q + 32'd4;
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               push    = 1'b1;
               state_d = S_REQ;
            end
         end
         S_DROP: begin
            if (imem_rvalid) begin
               state_d = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase
      // A redirect wins; drop only if a response is still owed
      if (flush) begin
         pc_d = branch_target & ~32'h3;
         push = 1'b0;
         if (gnt_ok
             || ((state_q == S_WAIT) && !imem_rvalid)
             || ((state_q == S_DROP) && !imem_rvalid)) begin
            state_d = S_DROP;
         end else begin
            state_d = S_REQ;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_REQ;
         pc_q     <= START_PC;
         req_pc_q <= 32'h0;
         run_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
         run_q    <= 1'b1;
      end
   end

   fetch_skid_buf u_skid (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_entry (push_entry),
      .consume    (!stall_disable),
      .clear      (flush),
      .out_entry  (out_entry),
      .skid_full  (skid_full)
   );

   assign PC_IFID_in          = out_entry.pc;
   assign PC_plus4_IFID_in    = out_entry.pc + 32'd4;
   assign instruction_IFID_in = out_entry.instr;
   assign valid_IFID_in       = out_entry.valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: cycle table, grant-time scoreboard,
// and hand sequences for redirects and mid-transaction reset.
module tb_if_fetch_stage;

   localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
   localparam logic [31:0] KEY    = 32'hA5A5_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        stall_disable;
   logic        flush;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] PC_IFID_in;
   logic [31:0] PC_plus4_IFID_in;
   logic [31:0] instruction_IFID_in;
   logic        valid_IFID_in;

   if_fetch_stage #(.RESET_PC(RST_PC)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .stall_disable       (stall_disable),
      .flush               (flush),
      .branch_target       (branch_target),
      .imem_req            (imem_req),
      .imem_addr           (imem_addr),
      .imem_gnt            (imem_gnt),
      .imem_rvalid         (imem_rvalid),
      .imem_rdata          (imem_rdata),
      .PC_IFID_in          (PC_IFID_in),
      .PC_plus4_IFID_in    (PC_plus4_IFID_in),
      .instruction_IFID_in (instruction_IFID_in),
      .valid_IFID_in       (valid_IFID_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
   } vec_t;

   vec_t        tbl [18];
   logic [31:0] sb_q [$];
   int          n_run;
   int          n_fail;

   // memory model state
   logic        pend;
   int          cnt;
   int          lat;
   logic [31:0] paddr;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      logic        g;
      logic        rv;
      logic [31:0] ga;
      logic [31:0] e;
      imem_rvalid = pend && (cnt == 1);
      imem_rdata  = imem_rvalid ? (paddr ^ KEY) : 32'hDEAD_BEEF;
      imem_gnt    = imem_req && !pend;
      #1;
      if (valid_IFID_in && !stall_disable && !flush) begin
         if (sb_q.size() == 0) begin
            n_run++;
            n_fail++;
            $display("FAIL sb_empty: got pc %h expected none",
                     PC_IFID_in);
         end else begin
            e = sb_q.pop_front();
            chk("sb_pc", PC_IFID_in, e);
            chk("sb_instr", instruction_IFID_in, e ^ KEY);
            chk("sb_pc4", PC_plus4_IFID_in, e + 32'd4);
         end
      end
      if (flush || !rst_n) sb_q.delete();
      if (imem_gnt && !flush && rst_n) sb_q.push_back(imem_addr);
      g  = imem_gnt;
      ga = imem_addr;
      rv = imem_rvalid;
      @(posedge clk);
      if (rv) pend = 1'b0;
      else if (pend) cnt--;
      if (g) begin
         pend  = 1'b1;
         cnt   = lat;
         paddr = ga;
      end
      @(negedge clk);
   endtask

   task automatic wait_req();
      for (int i = 0; i < 30; i++) begin
         if (imem_req) return;
         tick();
      end
      n_run++;
      n_fail++;
      $display("FAIL wait_req: got timeout expected imem_req");
   endtask

   task automatic wait_valid(input logic [31:0] pc, input string nm);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (valid_IFID_in) found = 1'b1;
         else begin
            chk({nm, "_nop"}, instruction_IFID_in, NOP);
            tick();
         end
      end
      if (found) chk(nm, PC_IFID_in, pc);
      else begin
         n_run++;
         n_fail++;
         $display("FAIL %s: got timeout expected pc %h", nm, pc);
      end
   endtask

   initial begin
      n_run         = 0;
      n_fail        = 0;
      pend          = 1'b0;
      cnt           = 0;
      lat           = 1;
      paddr         = 32'h0;
      rst_n         = 1'b0;
      stall_disable = 1'b0;
      flush         = 1'b0;
      branch_target = 32'h0;
      imem_gnt      = 1'b0;
      imem_rvalid   = 1'b0;
      imem_rdata    = 32'h0;

      //         stall req  addr           valid pc
      tbl[0]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
      tbl[1]  = '{1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0};
      tbl[2]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
      tbl[3]  = '{1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFF8};
      tbl[4]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
      tbl[5]  = '{1'b0, 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC};
      tbl[6]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
      tbl[7]  = '{1'b0, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000};
      tbl[8]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
      tbl[9]  = '{1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004};
      tbl[10] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0004};
      tbl[11] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0004};
      tbl[12] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0004};
      tbl[13] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0004};
      tbl[14] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0004};
      tbl[15] = '{1'b0, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_0008};
      tbl[16] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
      tbl[17] = '{1'b0, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_000C};

      @(negedge clk);
      chk("rst_req", {31'h0, imem_req}, 32'h0);
      chk("rst_valid", {31'h0, valid_IFID_in}, 32'h0);
      chk("rst_instr", instruction_IFID_in, NOP);
      chk("rst_pc", PC_IFID_in, 32'h0);
      chk("rst_pc4", PC_plus4_IFID_in, 32'h4);
      chk("rst_addr", imem_addr, RST_PC);
      tick();
      chk("rst_req2", {31'h0, imem_req}, 32'h0);
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         stall_disable = tbl[i].stall;
         chk($sformatf("row%0d_req", i), {31'h0, imem_req},
             {31'h0, tbl[i].req});
         if (tbl[i].req)
            chk($sformatf("row%0d_addr", i), imem_addr, tbl[i].addr);
         chk($sformatf("row%0d_valid", i), {31'h0, valid_IFID_in},
             {31'h0, tbl[i].valid});
         if (tbl[i].valid)
            chk($sformatf("row%0d_pc", i), PC_IFID_in, tbl[i].pc);
         tick();
      end
      stall_disable = 1'b0;

      // flush while waiting on a slow response -> S_DROP
      lat = 2;
      wait_req();
      tick();
      flush         = 1'b1;
      branch_target = 32'h0000_0103;
      tick();
      flush = 1'b0;
      chk("wflush_valid", {31'h0, valid_IFID_in}, 32'h0);
      chk("wflush_instr", instruction_IFID_in, NOP);
      chk("wflush_drop", {31'h0, imem_req}, 32'h0);
      tick();
      chk("wflush_req", {31'h0, imem_req}, 32'h1);
      chk("wflush_addr", imem_addr, 32'h0000_0100);
      wait_valid(32'h0000_0100, "wflush_first");

      // flush in the grant cycle -> S_DROP
      lat = 1;
      wait_req();
      flush         = 1'b1;
      branch_target = 32'h0000_0200;
      tick();
      flush = 1'b0;
      chk("gflush_drop", {31'h0, imem_req}, 32'h0);
      chk("gflush_valid", {31'h0, valid_IFID_in}, 32'h0);
      tick();
      chk("gflush_req", {31'h0, imem_req}, 32'h1);
      chk("gflush_addr", imem_addr, 32'h0000_0200);
      wait_valid(32'h0000_0200, "gflush_first");

      // flush together with rvalid -> straight to S_REQ
      for (int i = 0; i < 30 && !(pend && cnt == 1); i++) tick();
      chk("rflush_pending", {31'h0, pend}, 32'h1);
      flush         = 1'b1;
      branch_target = 32'h0000_0300;
      tick();
      flush = 1'b0;
      chk("rflush_req", {31'h0, imem_req}, 32'h1);
      chk("rflush_addr", imem_addr, 32'h0000_0300);
      chk("rflush_valid", {31'h0, valid_IFID_in}, 32'h0);
      wait_valid(32'h0000_0300, "rflush_first");

      // reset while a response is owed; it lands after release
      lat = 3;
      wait_req();
      tick();
      lat   = 1;
      rst_n = 1'b0;
      #1;
      chk("mrst_req", {31'h0, imem_req}, 32'h0);
      chk("mrst_valid", {31'h0, valid_IFID_in}, 32'h0);
      chk("mrst_addr", imem_addr, RST_PC);
      tick();
      rst_n = 1'b1;
      tick();
      chk("mrst_late_rvalid", {31'h0, pend && cnt == 1}, 32'h1);
      wait_valid(RST_PC, "mrst_first");

      for (int i = 0; i < 8; i++) tick();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
